// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: run-controller state encoding and halt-cause codes shared by
// cpu_run_ctrl and its testbench.
package cpu_ctrl_pkg;
    typedef enum logic [1:0] {ST_HOLD, ST_HALT, ST_RUN, ST_STEP} state_t;
    localparam logic [2:0] HC_NONE    = 3'd0;
    localparam logic [2:0] HC_POWERON = 3'd1;
    localparam logic [2:0] HC_CMD     = 3'd2;
    localparam logic [2:0] HC_BREAK   = 3'd3;
    localparam logic [2:0] HC_LIMIT   = 3'd4;
    localparam logic [2:0] HC_STEP    = 3'd5;
endpackage

// File: rtl/cpu_trace_buf.sv
// cpu_trace_buf: 1-entry valid/ready register slice holding {pc,inst} of the
// last retired instruction; a push may land on the same edge as a pop.
module cpu_trace_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [31:0]       i_inst,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [31:0]       o_inst
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_inst  <= '0;
        end else if (i_push) begin
            o_valid <= 1'b1;
            o_pc    <= i_pc;
            o_inst  <= i_inst;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step sequencer gating a single-cycle CPU via cpu_en.
// Define CPU_TRACE_EN to add the 1-entry retirement trace buffer (with stall).
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_run,
    input  logic              cmd_halt,
    input  logic              cmd_step,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_pc,
    input  logic [CNT_W-1:0]  inst_limit,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       inst,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              halted,
    output logic [2:0]        halt_cause,
    output logic [CNT_W-1:0]  retired,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [ADDR_W-1:0] trace_pc,
    output logic [31:0]       trace_inst
);
    localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
    state_t            r_state, w_next;
    logic [HW-1:0]     r_hold;
    logic              r_skip, w_set_skip, w_stall, w_bp, w_lim;
    logic [CNT_W-1:0]  r_retired;
    logic [2:0]        r_cause, w_cause;
`ifdef CPU_TRACE_EN
    cpu_trace_buf #(.ADDR_W(ADDR_W)) u_trace (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (cpu_en),
        .i_pc    (pc),
        .i_inst  (inst),
        .i_ready (trace_ready),
        .o_valid (trace_valid),
        .o_pc    (trace_pc),
        .o_inst  (trace_inst)
    );
    assign w_stall = trace_valid & ~trace_ready;
`else
    logic w_unused_trace;
    assign w_unused_trace = trace_ready ^ (^inst);
    assign w_stall     = 1'b0;
    assign trace_valid = 1'b0;
    assign trace_pc    = '0;
    assign trace_inst  = '0;
`endif
    assign w_bp       = bp_en && (pc == bp_pc) && !r_skip;
    assign w_lim      = (inst_limit != '0) && (r_retired == inst_limit);
    assign cpu_rst    = r_state == ST_HOLD;
    assign halted     = r_state == ST_HALT;
    assign halt_cause = r_cause;
    assign retired    = r_retired;
    // Stalls (trace full) freeze RUN/STEP without evaluating breakpoint or limit.
    always_comb begin
        w_next     = r_state;
        w_cause    = r_cause;
        w_set_skip = 1'b0;
        cpu_en     = 1'b0;
        case (r_state)
            ST_HOLD: if (r_hold == HW'(RESET_HOLD - 1)) begin
                w_next  = ST_HALT;
                w_cause = HC_POWERON;
            end
            ST_HALT: if (cmd_step || cmd_run) begin
                if (w_lim) w_cause = HC_LIMIT;
                else begin
                    w_next     = cmd_step ? ST_STEP : ST_RUN;
                    w_set_skip = 1'b1;
                end
            end
            ST_RUN: if (cmd_halt) begin
                w_next  = ST_HALT;
                w_cause = HC_CMD;
            end else if (!w_stall) begin
                if (w_bp || w_lim) begin
                    w_next  = ST_HALT;
                    w_cause = w_bp ? HC_BREAK : HC_LIMIT;
                end else cpu_en = 1'b1;
            end
            ST_STEP: if (!w_stall) begin
                w_next  = ST_HALT;
                w_cause = w_lim ? HC_LIMIT : HC_STEP;
                cpu_en  = !w_lim;
            end
            default: w_next = ST_HOLD;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_HOLD;
            r_hold    <= '0;
            r_skip    <= 1'b0;
            r_retired <= '0;
            r_cause   <= HC_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if (r_state == ST_HOLD) r_hold <= r_hold + 1'b1;
            if (w_set_skip) r_skip <= 1'b1;
            else if (cpu_en) r_skip <= 1'b0;
            if (cpu_en && !(&r_retired)) r_retired <= r_retired + 1'b1;
        end
    end
endmodule
